// File: rtl/timer_mode_ctrl.sv
// Mode controller for a two-digit BCD countdown timer. It owns the set-entry
// digits and the running count, and selects which pair is shown on the display.
module timer_mode_ctrl #(
  parameter int DEFAULT_TENS = 6,
  parameter int DEFAULT_ONES = 0,
  parameter int ALARM_TICKS  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       btn_start,
  output logic       mux,
  output logic [3:0] ber1,
  output logic [3:0] ber2,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic       digit_sel,
  output logic       running,
  output logic       done,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] DEF_TENS  = 4'(DEFAULT_TENS);
  localparam logic [3:0] DEF_ONES  = 4'(DEFAULT_ONES);
  localparam logic [3:0] ALARM_LIM = 4'(ALARM_TICKS);

  state_t     state, state_n;
  logic [3:0] num1_n, num2_n;
  logic [3:0] ber1_n, ber2_n;
  logic       sel_n;
  logic [3:0] alarm, alarm_n;

  logic [3:0] dec_tens, dec_ones;
  logic       cnt_zero, dec_zero, any_btn;

  function automatic logic [3:0] inc10(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  assign cnt_zero  = (num1 == 4'd0) && (num2 == 4'd0);
  assign any_btn   = btn_mode | btn_start | btn_sel | btn_inc;
  assign state_dbg = state;

  // BCD decrement with borrow; only applied when the count is non-zero.
  always_comb begin
    dec_tens = num1;
    dec_ones = num2;
    if (num2 != 4'd0) begin
      dec_ones = num2 - 4'd1;
    end else if (num1 != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = num1 - 4'd1;
    end
    dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);
  end

  always_comb begin
    state_n = state;
    num1_n  = num1;
    num2_n  = num2;
    ber1_n  = ber1;
    ber2_n  = ber2;
    sel_n   = digit_sel;
    alarm_n = alarm;
    unique case (state)
      IDLE: begin
        if (btn_mode) begin
          state_n = SET;
          sel_n   = 1'b0;
        end else if (btn_start && !cnt_zero) begin
          state_n = RUN;
        end
      end
      SET: begin
        if (btn_mode) begin
          state_n = IDLE;
          num1_n  = ber1;
          num2_n  = ber2;
        end else if (btn_sel) begin
          sel_n = ~digit_sel;
        end else if (btn_inc) begin
          if (digit_sel) ber2_n = inc10(ber2);
          else           ber1_n = inc10(ber1);
        end
      end
      RUN: begin
        // A start press together with a tick still takes the decrement;
        // reaching zero wins over pausing.
        if (tick && !cnt_zero) begin
          num1_n = dec_tens;
          num2_n = dec_ones;
          if (dec_zero) begin
            state_n = DONE;
            alarm_n = 4'd0;
          end else if (btn_start) begin
            state_n = PAUSE;
          end
        end else if (btn_start) begin
          state_n = PAUSE;
        end
      end
      PAUSE: begin
        if (btn_mode) begin
          state_n = IDLE;
          num1_n  = ber1;
          num2_n  = ber2;
        end else if (btn_start) begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (any_btn) begin
          state_n = IDLE;
          num1_n  = ber1;
          num2_n  = ber2;
          alarm_n = 4'd0;
        end else if (tick) begin
          if (alarm + 4'd1 >= ALARM_LIM) begin
            state_n = IDLE;
            num1_n  = ber1;
            num2_n  = ber2;
            alarm_n = 4'd0;
          end else begin
            alarm_n = alarm + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        alarm_n = 4'd0;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they move with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      num1      <= DEF_TENS;
      num2      <= DEF_ONES;
      ber1      <= DEF_TENS;
      ber2      <= DEF_ONES;
      digit_sel <= 1'b0;
      alarm     <= 4'd0;
      mux       <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      num1      <= num1_n;
      num2      <= num2_n;
      ber1      <= ber1_n;
      ber2      <= ber2_n;
      digit_sel <= sel_n;
      alarm     <= alarm_n;
      mux       <= (state_n == SET);
      running   <= (state_n == RUN);
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: doc/timer_mode_ctrl.md
# timer_mode_ctrl

Mode controller for the two-digit BCD countdown timer. It sequences the display-select mux between the live count and the set-entry digits, owns the set-entry digits (`ber1`/`ber2`), and owns the running count (`num1`/`num2`). It sits between the debounced button pulses and the display-select mux, and drives `mux`, `num1`/`num2` and `ber1`/`ber2` directly.

## Interface
- `DEFAULT_TENS`, 6: reset value of the tens digit, both set and count.
- `DEFAULT_ONES`, 0: reset value of the ones digit, both set and count.
- `ALARM_TICKS`, 5: number of `tick` pulses spent in DONE before auto-return to IDLE; range 1–15.
- `clk` in 1: single clock; all logic rises on its posedge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle count-rate enable (1 Hz in system).
- `btn_mode` in 1: one-cycle pulse; enter or leave SET.
- `btn_sel` in 1: one-cycle pulse; toggle the edited digit in SET.
- `btn_inc` in 1: one-cycle pulse; increment the edited digit in SET.
- `btn_start` in 1: one-cycle pulse; start or pause.
- `mux` out 1: 1 selects set digits for display; 0 selects the count.
- `ber1`, `ber2` out 4 each: set digits, tens and ones, BCD 0–9.
- `num1`, `num2` out 4 each: count digits, tens and ones, BCD 0–9.
- `digit_sel` out 1: 0 means tens is being edited, 1 means ones.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, SET, RUN, PAUSE, DONE. State is encoded in a 3-bit register.
- Reset values:
  - state IDLE.
  - `ber1` = `num1` = DEFAULT_TENS; `ber2` = `num2` = DEFAULT_ONES.
  - `mux`, `digit_sel`, `running`, `done` = 0.
  - alarm counter = 0.
- Button priority when several pulses arrive in one cycle: `btn_mode` > `btn_start` > `btn_sel` > `btn_inc`. Only the highest-priority pulse that is valid in the current state acts.
- IDLE:
  - `btn_mode` goes to SET and clears `digit_sel`.
  - `btn_start` goes to RUN only if count ≠ 00; at 00 it is ignored.
- SET (`mux` = 1):
  - `btn_sel` toggles `digit_sel`.
  - `btn_inc` increments the selected set digit modulo 10 (9 wraps to 0, both digits).
  - `btn_mode` goes to IDLE and loads `{num1,num2}` from `{ber1,ber2}`.
  - `btn_start` and `tick` are ignored.
- RUN:
  - On `tick`, the count decrements as BCD: if ones > 0, ones−1; otherwise ones = 9 and tens−1.
  - If the decremented value is 00, go to DONE.
  - `btn_start` goes to PAUSE.
  - `btn_mode` is ignored.
- RUN, `tick` and `btn_start` in the same cycle: the decrement is applied. The next state is DONE if the result is 00, otherwise PAUSE.
- PAUSE:
  - Count is held; `tick` is ignored.
  - `btn_start` goes to RUN.
  - `btn_mode` goes to IDLE and reloads the count from the set digits.
- DONE:
  - `done` = 1 and count holds 00.
  - Each `tick` increments the alarm counter. When the counter reaches ALARM_TICKS, go to IDLE, reload the count, and clear the counter.
  - Any button pulse goes to IDLE immediately, reloads the count, and clears the counter.
- `ber1`/`ber2` change only in SET or on reset. Count digits never leave the range 0–9; 00 is never decremented.

## Timing
- All outputs are registered.
- A pulse or `tick` in cycle N is reflected in state and outputs at cycle N+1.
- `mux`, `running` and `done` are decoded from next-state into registers, so they change in the same cycle as the state.
- Reload on entering IDLE is visible at N+1.
- A count of 01 reaches 00 and DONE in the same cycle, N+1 after the `tick`.
- A `rst` asserted mid-RUN or mid-SET returns to reset values at the next edge. `rst` overrides all inputs that cycle.
- No combinational path from any input to any output.

## Test plan
- Reset, then hold idle: `mux` = 0, `num` = `ber` = 6/0, `running` = `done` = 0.
- Enter SET:
  - Stimulus: `btn_mode`, `btn_inc` ×3 (tens 6→9), `btn_inc` (tens 9→0), `btn_sel`, `btn_inc` ×2, then `btn_mode`.
  - Required: `ber` = 0/2, `num` = 0/2 one cycle after exit, `mux` back to 0.
- Count down:
  - Stimulus: count 1/0, `btn_start`, then `tick` ×1.
  - Required: `num` = 0/9 (borrow). After 9 more ticks, `num` = 0/0, `done` = 1, `running` = 0 in the same cycle.
- Pause and resume:
  - Stimulus: RUN at 0/5, `tick` and `btn_start` in the same cycle.
  - Required: `num` = 0/4 and PAUSE. A further `tick` leaves 0/4. `btn_start` resumes RUN.
- DONE exit:
  - With ALARM_TICKS = 5: 5 ticks return to IDLE with `num` = `ber`.
  - On a rerun, `btn_inc` after 2 ticks returns to IDLE immediately.
- Boundary checks:
  - `btn_start` at count 0/0 in IDLE stays in IDLE.
  - `btn_mode` and `btn_start` together in IDLE go to SET.
  - `rst` during RUN at 3/7 restores 6/0 next cycle.
